// File: rtl/core5_debug_halt_ctrl_if.sv
// -----------------------------------------------------------------------------
// core5_debug_halt_ctrl_if
//
// Bundles the signals exchanged between the cross-core halt sequencer and its
// surroundings (CPU debug-acknowledge lines, host halt/resume pulses, per-core
// debug requests and status).
//
// Modports:
//   slave  - the sequencer itself: samples debugack/core_enable/halt_req/
//            resume_req, drives debugreq and all status outputs.
//   master - the system side (CPUs, host, test harness): the mirror image.
//
// Signals:
//   debugack     [NUM_CORES] per-core debug acknowledge (level)
//   core_enable  [NUM_CORES] cores taking part in cross-halt
//   halt_req                 one-cycle host pulse: global halt
//   resume_req               one-cycle host pulse: global resume
//   debugreq     [NUM_CORES] per-core debug request (registered)
//   state        [2]         0=IDLE 1=HALTING 2=HALTED 3=RESUMING
//   halted_mask  [NUM_CORES] snapshot of acked, latched-enabled cores
//   origin_core  [3]         lowest-index core whose break started the halt
//   origin_valid             halt was core-initiated
//   timeout_err              last HALTING/RESUMING wait expired (sticky)
//   busy                     HALTING or RESUMING
// -----------------------------------------------------------------------------
interface core5_debug_halt_ctrl_if #(
   parameter int NUM_CORES = 5
);
   logic [NUM_CORES-1:0] debugack;
   logic [NUM_CORES-1:0] core_enable;
   logic                 halt_req;
   logic                 resume_req;
   logic [NUM_CORES-1:0] debugreq;
   logic [1:0]           state;
   logic [NUM_CORES-1:0] halted_mask;
   logic [2:0]           origin_core;
   logic                 origin_valid;
   logic                 timeout_err;
   logic                 busy;

   modport master (
      output debugack, core_enable, halt_req, resume_req,
      input  debugreq, state, halted_mask, origin_core, origin_valid,
             timeout_err, busy
   );

   modport slave (
      input  debugack, core_enable, halt_req, resume_req,
      output debugreq, state, halted_mask, origin_core, origin_valid,
             timeout_err, busy
   );
endinterface

// File: rtl/core5_debug_halt_ctrl.sv
// -----------------------------------------------------------------------------
// core5_debug_halt_ctrl
//
// Cross-core halt/resume sequencer. When an enabled core breaks (rising
// debugack) or the host pulses halt_req, every other enabled core is sent
// debugreq so that all cores stop together. Cores stay halted until the host
// pulses resume_req; the sequencer then drops debugreq and waits for the acks
// to fall. Both waits are bounded by TIMEOUT; an expired wait still advances
// the sequence but raises the sticky timeout_err flag.
//
// Ports:
//   clk    system clock (single domain)
//   reset  synchronous, active-high reset
//   bus    core5_debug_halt_ctrl_if.slave - debugack/core_enable/halt_req/
//          resume_req in; debugreq, state, halted_mask, origin_core,
//          origin_valid, timeout_err, busy out. Every output is registered.
// -----------------------------------------------------------------------------
module core5_debug_halt_ctrl #(
   parameter int NUM_CORES = 5,
   parameter int TIMEOUT   = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   core5_debug_halt_ctrl_if.slave  bus
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HALTING  = 2'd1,
      HALTED   = 2'd2,
      RESUMING = 2'd3
   } state_t;

   state_t               state_reg,        state_next;
   logic [NUM_CORES-1:0] ack_q_reg;
   logic [NUM_CORES-1:0] en_lat_reg,       en_lat_next;
   logic [NUM_CORES-1:0] debugreq_reg,     debugreq_next;
   logic [NUM_CORES-1:0] halted_mask_reg,  halted_mask_next;
   logic [CW-1:0]        cnt_reg,          cnt_next;
   logic [2:0]           origin_core_reg,  origin_core_next;
   logic                 origin_valid_reg, origin_valid_next;
   logic                 timeout_err_reg,  timeout_err_next;
   logic                 busy_reg,         busy_next;

   logic [NUM_CORES-1:0] rise;
   logic [NUM_CORES-1:0] acked;
   logic [2:0]           rise_low;
   logic                 all_acked;
   logic                 none_acked;
   logic                 cnt_expired;

   // Per-core break detection uses the live enable (a disabled core breaking
   // must not drag the others down); completion uses the latched enable.
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign rise[gi]  = bus.debugack[gi] & ~ack_q_reg[gi] & bus.core_enable[gi];
      assign acked[gi] = bus.debugack[gi] & en_lat_reg[gi];
   end

   assign all_acked   = (acked == en_lat_reg);
   assign none_acked  = (acked == '0);
   assign cnt_expired = (cnt_reg == CW'(TIMEOUT));

   // Lowest-index breaking core wins the origin slot. Scanning downward lets
   // the last (lowest) hit overwrite the earlier ones.
   always_comb begin
      rise_low = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (rise[i]) begin
            rise_low = 3'(i);
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next        = state_reg;
      en_lat_next       = en_lat_reg;
      debugreq_next     = debugreq_reg;
      cnt_next          = cnt_reg;
      origin_core_next  = origin_core_reg;
      origin_valid_next = origin_valid_reg;
      timeout_err_next  = timeout_err_reg;

      case (state_reg)
         IDLE: begin
            debugreq_next = '0;
            if ((rise != '0) || bus.halt_req) begin
               state_next        = HALTING;
               en_lat_next       = bus.core_enable;
               // Cores already in debug mode are not re-requested on the first
               // HALTING cycle; the full mask follows one cycle later.
               debugreq_next     = bus.core_enable & ~bus.debugack;
               cnt_next          = '0;
               timeout_err_next  = 1'b0;
               origin_valid_next = (rise != '0);
               origin_core_next  = rise_low;
            end
         end

         HALTING: begin
            debugreq_next = en_lat_reg;
            cnt_next      = cnt_reg + CW'(1);
            if (all_acked) begin
               state_next = HALTED;
               cnt_next   = '0;
            end else if (cnt_expired) begin
               state_next       = HALTED;
               cnt_next         = '0;
               timeout_err_next = 1'b1;
            end
         end

         HALTED: begin
            debugreq_next = en_lat_reg;
            if (bus.resume_req) begin
               state_next    = RESUMING;
               debugreq_next = '0;
               cnt_next      = '0;
            end
         end

         RESUMING: begin
            debugreq_next = '0;
            cnt_next      = cnt_reg + CW'(1);
            if (none_acked) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_expired) begin
               state_next       = IDLE;
               cnt_next         = '0;
               timeout_err_next = 1'b1;
            end
         end

         default: begin
            state_next    = IDLE;
            debugreq_next = '0;
         end
      endcase

      // Gating on the next state keeps the mask at zero for every cycle the
      // state output reads IDLE, including right after a timed-out resume.
      if (state_next == IDLE) begin
         halted_mask_next = '0;
      end else begin
         halted_mask_next = bus.debugack & en_lat_next;
      end

      busy_next = (state_next == HALTING) || (state_next == RESUMING);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         ack_q_reg        <= '0;
         en_lat_reg       <= '0;
         debugreq_reg     <= '0;
         halted_mask_reg  <= '0;
         cnt_reg          <= '0;
         origin_core_reg  <= '0;
         origin_valid_reg <= 1'b0;
         timeout_err_reg  <= 1'b0;
         busy_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         ack_q_reg        <= bus.debugack;
         en_lat_reg       <= en_lat_next;
         debugreq_reg     <= debugreq_next;
         halted_mask_reg  <= halted_mask_next;
         cnt_reg          <= cnt_next;
         origin_core_reg  <= origin_core_next;
         origin_valid_reg <= origin_valid_next;
         timeout_err_reg  <= timeout_err_next;
         busy_reg         <= busy_next;
      end
   end

   assign bus.debugreq     = debugreq_reg;
   assign bus.state        = state_reg;
   assign bus.halted_mask  = halted_mask_reg;
   assign bus.origin_core  = origin_core_reg;
   assign bus.origin_valid = origin_valid_reg;
   assign bus.timeout_err  = timeout_err_reg;
   assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_core5_debug_halt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core5_debug_halt_ctrl
//
// Directed scenarios followed by a randomized phase. A small CPU responder
// raises each core's debugack some cycles after its debug request and drops
// it some cycles into a resume. A reference model, written from the halt/
// resume rules (cycles spent waiting, sets of acked cores), predicts every
// output after every clock edge.
// -----------------------------------------------------------------------------
module tb_core5_debug_halt_ctrl;
   localparam int N  = 5;
   localparam int TO = 15;

   localparam int S_IDLE     = 0;
   localparam int S_HALTING  = 1;
   localparam int S_HALTED   = 2;
   localparam int S_RESUMING = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   core5_debug_halt_ctrl_if #(.NUM_CORES(N)) bus ();

   core5_debug_halt_ctrl #(.NUM_CORES(N), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // stimulus
   logic [N-1:0] ack, en;
   logic         hreq, rreq;
   logic [N-1:0] stuck;   // cores that never acknowledge a request
   logic [N-1:0] pinned;  // cores that never release their ack
   int up_lat [N];
   int dn_lat [N];
   int up_cnt [N];
   int dn_cnt [N];

   // reference model
   int           m_state;
   int           m_spent;  // edges spent in the current waiting state
   logic [N-1:0] m_req, m_mask, m_en, m_ackq;
   logic [2:0]   m_oc;
   logic         m_ov, m_err;

   function automatic logic [2:0] lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   // Predict the effect of the coming clock edge from the inputs now applied.
   task automatic model_edge();
      logic [N-1:0] brk;
      int nxt;
      if (reset) begin
         m_state = S_IDLE; m_spent = 0; m_req = '0; m_mask = '0; m_en = '0;
         m_ackq = '0; m_oc = '0; m_ov = 1'b0; m_err = 1'b0;
         return;
      end
      brk = ack & ~m_ackq & en;
      nxt = m_state;
      if (m_state == S_IDLE) begin
         m_req = '0;
         if (brk != '0 || hreq) begin
            nxt   = S_HALTING;
            m_en  = en;
            m_req = en & ~ack;
            m_err = 1'b0;
            m_ov  = (brk != '0);
            m_oc  = lowest(brk);
         end
      end else if (m_state == S_HALTING) begin
         m_req = m_en;
         m_spent++;
         if ((ack & m_en) == m_en) nxt = S_HALTED;
         else if (m_spent == TO + 1) begin nxt = S_HALTED; m_err = 1'b1; end
      end else if (m_state == S_HALTED) begin
         m_req = m_en;
         if (rreq) begin nxt = S_RESUMING; m_req = '0; end
      end else begin
         m_req = '0;
         m_spent++;
         if ((ack & m_en) == '0) nxt = S_IDLE;
         else if (m_spent == TO + 1) begin nxt = S_IDLE; m_err = 1'b1; end
      end
      if (nxt != m_state) m_spent = 0;
      m_mask  = (nxt == S_IDLE) ? '0 : (ack & m_en);
      m_state = nxt;
      m_ackq  = ack;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic m_busy;
      m_busy = (m_state == S_HALTING) || (m_state == S_RESUMING);
      check("state",        32'(bus.state),        32'(m_state));
      check("debugreq",     32'(bus.debugreq),     32'(m_req));
      check("halted_mask",  32'(bus.halted_mask),  32'(m_mask));
      check("origin_core",  32'(bus.origin_core),  32'(m_oc));
      check("origin_valid", 32'(bus.origin_valid), 32'(m_ov));
      check("timeout_err",  32'(bus.timeout_err),  32'(m_err));
      check("busy",         32'(bus.busy),         32'(m_busy));
   endtask

   // CPU behaviour: ack after up_lat cycles of request, release after dn_lat
   // cycles of resume.
   task automatic respond();
      for (int i = 0; i < N; i++) begin
         if (m_req[i] && !ack[i] && !stuck[i]) begin
            up_cnt[i]++;
            if (up_cnt[i] >= up_lat[i]) ack[i] = 1'b1;
         end else begin
            up_cnt[i] = 0;
         end
         if (m_state == S_RESUMING && ack[i] && !pinned[i]) begin
            dn_cnt[i]++;
            if (dn_cnt[i] >= dn_lat[i]) ack[i] = 1'b0;
         end else begin
            dn_cnt[i] = 0;
         end
      end
   endtask

   task automatic step();
      int prev;
      prev = m_state;
      bus.debugack    = ack;
      bus.core_enable = en;
      bus.halt_req    = hreq;
      bus.resume_req  = rreq;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
      if (m_state != prev)
         $display("txn t=%0t state %0d->%0d req=%b mask=%b origin=%0d/%0d err=%0d",
                  $time, prev, m_state, m_req, m_mask, m_oc, m_ov, m_err);
      hreq = 1'b0;
      rreq = 1'b0;
      respond();
   endtask

   task automatic wait_state(input string tag, input int target, input int limit, output int cycles);
      cycles = 0;
      while (int'(bus.state) != target && cycles < limit) begin
         step();
         cycles++;
      end
      total++;
      assert (int'(bus.state) == target) else begin
         bad++;
         $error("FAIL %s wait expired state=%0d expected=%0d", tag, bus.state, target);
      end
   endtask

   task automatic set_lat(input int up, input int dn);
      for (int i = 0; i < N; i++) begin
         up_lat[i] = up; dn_lat[i] = dn; up_cnt[i] = 0; dn_cnt[i] = 0;
      end
   endtask

   initial begin
      int cyc;
      int k;
      ack = '0; en = '0; hreq = 1'b0; rreq = 1'b0; stuck = '0; pinned = '0;
      m_state = S_IDLE; m_spent = 0; m_req = '0; m_mask = '0; m_en = '0;
      m_ackq = '0; m_oc = '0; m_ov = 1'b0; m_err = 1'b0;
      set_lat(3, 4);

      // reset state
      reset = 1'b1;
      step();
      step();
      check("reset.state", 32'(bus.state), 32'(S_IDLE));
      check("reset.debugreq", 32'(bus.debugreq), 32'(0));
      reset = 1'b0;

      // core-initiated halt: core 2 breaks, others ack 3 cycles after request
      en = 5'b11111;
      for (int i = 0; i < 3; i++) step();
      ack[2] = 1'b1;
      step();
      check("core_halt.first_req", 32'(bus.debugreq), 32'(5'b11011));
      step();
      check("core_halt.full_req", 32'(bus.debugreq), 32'(5'b11111));
      wait_state("core_halt.halted", S_HALTED, 10, cyc);
      check("core_halt.latency_ok", 32'(cyc + 1 <= 4), 32'(1));
      check("core_halt.origin_core", 32'(bus.origin_core), 32'(2));
      check("core_halt.origin_valid", 32'(bus.origin_valid), 32'(1));
      rreq = 1'b1;
      step();
      wait_state("core_halt.idle", S_IDLE, 30, cyc);

      // host halt/resume, resume_req ignored in IDLE and HALTING
      set_lat(2, 4);
      rreq = 1'b1;
      step();
      check("host.resume_in_idle", 32'(bus.state), 32'(S_IDLE));
      hreq = 1'b1;
      step();
      rreq = 1'b1;
      step();
      check("host.resume_in_halting", 32'(bus.state), 32'(S_HALTING));
      wait_state("host.halted", S_HALTED, 10, cyc);
      check("host.origin_valid", 32'(bus.origin_valid), 32'(0));
      rreq = 1'b1;
      step();
      check("host.resuming", 32'(bus.state), 32'(S_RESUMING));
      wait_state("host.idle", S_IDLE, 30, cyc);
      check("host.idle_after_5", 32'(cyc + 1), 32'(5));
      check("host.no_timeout", 32'(bus.timeout_err), 32'(0));

      // halt timeout: core 4 never acks
      set_lat(1, 2);
      stuck = 5'b10000;
      hreq = 1'b1;
      step();
      wait_state("timeout.halted", S_HALTED, 40, cyc);
      check("timeout.cycles", 32'(cyc), 32'(TO + 1));
      check("timeout.err", 32'(bus.timeout_err), 32'(1));
      check("timeout.mask", 32'(bus.halted_mask), 32'(5'b01111));
      rreq = 1'b1;
      step();
      wait_state("timeout.idle", S_IDLE, 30, cyc);
      check("timeout.sticky", 32'(bus.timeout_err), 32'(1));
      stuck = '0;

      // simultaneous halt_req with core 0 and core 3 breaks
      ack = '0;
      step();
      ack = 5'b01001;
      hreq = 1'b1;
      step();
      check("simul.origin_core", 32'(bus.origin_core), 32'(0));
      check("simul.origin_valid", 32'(bus.origin_valid), 32'(1));
      check("simul.err_cleared", 32'(bus.timeout_err), 32'(0));
      wait_state("simul.halted", S_HALTED, 10, cyc);
      rreq = 1'b1;
      step();
      wait_state("simul.idle", S_IDLE, 30, cyc);

      // latched enable ignores later changes; reset in HALTED
      set_lat(2, 2);
      ack = '0;
      en = 5'b00101;
      hreq = 1'b1;
      step();
      en = 5'b11111;
      for (int i = 0; i < 3; i++) begin
         step();
         check("mask.debugreq", 32'(bus.debugreq), 32'(5'b00101));
      end
      check("mask.halted", 32'(bus.state), 32'(S_HALTED));
      reset = 1'b1;
      step();
      check("reset_halted.debugreq", 32'(bus.debugreq), 32'(0));
      check("reset_halted.state", 32'(bus.state), 32'(S_IDLE));
      reset = 1'b0;
      ack = '0;
      step();

      // no cores enabled: one-cycle halt and resume
      en = '0;
      hreq = 1'b1;
      step();
      wait_state("empty.halted", S_HALTED, 5, cyc);
      check("empty.halt_cycles", 32'(cyc), 32'(1));
      rreq = 1'b1;
      step();
      wait_state("empty.idle", S_IDLE, 5, cyc);
      check("empty.resume_cycles", 32'(cyc), 32'(1));

      // resume timeout: core 1 never releases
      en = 5'b11111;
      set_lat(1, 2);
      pinned = 5'b00010;
      hreq = 1'b1;
      step();
      wait_state("rtimeout.halted", S_HALTED, 10, cyc);
      rreq = 1'b1;
      step();
      wait_state("rtimeout.idle", S_IDLE, 40, cyc);
      check("rtimeout.cycles", 32'(cyc), 32'(TO + 1));
      check("rtimeout.err", 32'(bus.timeout_err), 32'(1));
      pinned = '0;
      ack = '0;
      step();

      // randomized phase
      for (int c = 0; c < 600; c++) begin
         if (m_state == S_IDLE) begin
            if ($urandom_range(0, 3) == 0) ack = '0;
            if ($urandom_range(0, 5) == 0) en = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
               up_lat[i] = int'($urandom_range(1, 5));
               dn_lat[i] = int'($urandom_range(1, 5));
            end
            stuck  = '0;
            pinned = '0;
            if ($urandom_range(0, 5) == 0) stuck[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 5) == 0) pinned[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
               k = int'($urandom_range(0, N - 1));
               ack[k] = 1'b1;
            end
            hreq = ($urandom_range(0, 9) == 0);
            rreq = ($urandom_range(0, 4) == 0);
         end else begin
            if ($urandom_range(0, 7) == 0) en = N'($urandom_range(0, (1 << N) - 1));
            hreq = ($urandom_range(0, 5) == 0);
            rreq = (m_state == S_HALTED) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 5) == 0);
         end
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/core5_debug_halt_ctrl.md
# core5_debug_halt_ctrl

Cross-core halt/resume sequencer for the 5-core Nios II system. It watches each CPU's debug-acknowledge output. When one core breaks, or the host requests a global halt, it drives `debugreq` to every other enabled core so that all cores stop together. It then holds them halted until a resume command, and sequences the release. It sits beside the per-core JTAG debug modules in the system clock domain and drives each CPU's `debugreq` input.

## Interface
- `NUM_CORES`, 5: number of CPU cores sequenced.
- `TIMEOUT`, 255: maximum cycles to wait for ack assertion or deassertion. The counter width is `$clog2(TIMEOUT+1)`.
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `debugack`  in  NUM_CORES: per-core debug-acknowledge from the CPUs; level.
- `core_enable`  in  NUM_CORES: cores taking part in cross-halt. Latched on entry to HALTING.
- `halt_req`  in  1: one-cycle host pulse requesting a global halt.
- `resume_req`  in  1: one-cycle host pulse requesting a global resume.
- `debugreq`  out  NUM_CORES: per-core debug request; registered.
- `state`  out  2: 0=IDLE, 1=HALTING, 2=HALTED, 3=RESUMING.
- `halted_mask`  out  NUM_CORES: registered snapshot of `debugack & en_lat`, updated every cycle outside IDLE.
- `origin_core`  out  3: lowest-index core whose break triggered the halt.
- `origin_valid`  out  1: 1 if the halt was core-initiated; 0 if it was host-initiated.
- `timeout_err`  out  1: set if the HALTING or RESUMING wait expired; cleared on entry to HALTING.
- `busy`  out  1: high in HALTING and RESUMING.

## Operation
- Edge detect: `ack_q <= debugack` every cycle.
  - `rise = debugack & ~ack_q & core_enable`.
- IDLE:
  - If `rise != 0` or `halt_req`, go to HALTING.
  - On that transition:
    - `en_lat <= core_enable`.
    - `debugreq <= core_enable & ~debugack`.
    - Counter cleared; `timeout_err <= 0`.
    - `origin_valid <= (rise != 0)`; `origin_core <=` lowest set bit of `rise`.
  - If `halt_req` and `rise` occur together, this is treated as core-initiated (origin from `rise`).
  - `resume_req` is ignored.
- HALTING:
  - `debugreq` holds `en_lat`. Bits for already-acked cores are also set from the second HALTING cycle on.
  - If `(debugack & en_lat) == en_lat`, go to HALTED.
  - Else if counter == TIMEOUT, go to HALTED with `timeout_err <= 1`. `halted_mask` shows which cores actually stopped.
  - The counter increments every cycle while in this state.
- HALTED:
  - `debugreq` holds `en_lat`.
  - `resume_req` moves to RESUMING: `debugreq <= 0`, counter cleared.
  - `halt_req` and `rise` are ignored.
- RESUMING:
  - `debugreq = 0`.
  - If `(debugack & en_lat) == 0`, go to IDLE.
  - Else if counter == TIMEOUT, go to IDLE with `timeout_err <= 1`.
  - The origin core releases its own ack via its JTAG monitor; the controller only waits.
- Edge cases:
  - If `en_lat == 0` (no cores enabled), HALTING completes in one cycle and RESUMING exits in one cycle.
  - `core_enable` changes after latching have no effect until the next IDLE → HALTING transition.
  - In IDLE, `halted_mask` holds 0.
  - `timeout_err` is sticky through IDLE until the next halt.

## Timing
- Reset values, all set on the first `clk` edge with `reset`=1:
  - `debugreq` = 0, `state` = IDLE.
  - `halted_mask` = 0, `origin_core` = 0, `origin_valid` = 0.
  - `timeout_err` = 0, `busy` = 0.
  - Internal: `ack_q` = 0, `en_lat` = 0, counter = 0.
- Reset mid-operation: `debugreq` drops on the next edge regardless of state, and no resume sequencing occurs.
- Halt latency:
  - `debugack` rises at edge N; `rise` is seen in cycle N.
  - `debugreq` and `state`=HALTING are visible after edge N+1.
- Completion: all acks are high at edge M, so `state`=HALTED after edge M+1.
- Resume: `resume_req` is sampled at edge R; `debugreq`=0 and RESUMING are visible after R+1.
- Timeout: the wait expires after exactly TIMEOUT+1 cycles in HALTING or RESUMING without completion.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Core-initiated halt:
  - Stimulus: `core_enable`=5'b11111; core 2 `debugack` rises at cycle 10; the other acks rise 3 cycles after their `debugreq`.
  - Required response:
    - `debugreq`=5'b11011 at cycle 11, then 5'b11111.
    - HALTED by cycle 15.
    - `origin_core`=2, `origin_valid`=1.
- Host halt/resume:
  - Stimulus: `halt_req` pulse with no acks high; acks follow 2 cycles after `debugreq`; then `resume_req`; acks fall 4 cycles later.
  - Required response:
    - HALTED with `origin_valid`=0.
    - RESUMING, then IDLE 5 cycles after `resume_req`.
    - `timeout_err`=0.
- Halt timeout:
  - Stimulus: TIMEOUT=15; core 4 never acks.
  - Required response:
    - HALTED exactly 16 cycles after entering HALTING.
    - `timeout_err`=1, `halted_mask`=5'b01111.
- Simultaneous events:
  - Stimulus 1: `halt_req` and core 0/core 3 breaks in the same cycle. Required response: `origin_core`=0, `origin_valid`=1.
  - Stimulus 2: `resume_req` in IDLE or HALTING. Required response: ignored; `state` unchanged.
- Mask and reset:
  - Stimulus 1: `core_enable`=5'b00101 at entry, then changed to 5'b11111 while HALTING. Required response: `debugreq` stays 5'b00101.
  - Stimulus 2: `reset` asserted in HALTED. Required response: all outputs are 0 on the next edge.
